// File: rtl/spi_arbiter.sv
// spi_arbiter
// Round-robin arbiter sharing one SPI master among N register-access clients.
// A granted request is latched, handed to the master through its level-held
// start/done handshake, and completed with a one-cycle ack to the requester.
//
// Optional feature: define SPI_ARB_TIMEOUT_EN to build a watchdog that aborts
// a transaction after TIMEOUT_CYCLES in ISSUE/RELEASE (ack pulses with err).
// Without it err stays 0 and the handshake waits indefinitely.
//
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   req/req_wr             per-requester request and write(1)/read(0) select
//   req_addr/req_wdata     8 bits per requester, requester i at [8i+7:8i]
//   ack                    one-cycle completion pulse to the granted requester
//   err                    pulses with ack when a transaction timed out
//   rdata                  last read data, held between reads
//   grant_id               current or last granted requester
//   arb_busy               high whenever the FSM is not idle
//   spi_start/wr/addr/wdata  to the SPI master
//   spi_rdata/done/busy    from the SPI master (busy is informational only)
module spi_arbiter #(
  parameter int unsigned N              = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   req_wr,
  input  logic [8*N-1:0] req_addr,
  input  logic [8*N-1:0] req_wdata,
  output logic [N-1:0]   ack,
  output logic           err,
  output logic [7:0]     rdata,
  output logic [2:0]     grant_id,
  output logic           arb_busy,
  output logic           spi_start,
  output logic           spi_wr,
  output logic [7:0]     spi_addr,
  output logic [7:0]     spi_wdata,
  input  logic [7:0]     spi_rdata,
  input  logic           spi_done,
  input  logic           spi_busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RELEASE,
    S_ACK
  } state_e;

  localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  state_e         state_q;
  logic [2:0]     last_q;
  logic [N-1:0]   ack_q;
  logic           err_q;
  logic [7:0]     rdata_q;
  logic [2:0]     grant_q;
  logic           busy_q;
  logic           start_q;
  logic           wr_q;
  logic [7:0]     addr_q;
  logic [7:0]     wdata_q;

  // Round-robin winner: scan offsets from N down to 1 so the smallest offset
  // after last_q overwrites any later candidate.
  logic [2:0]     win_d;
  logic           any_d;
  logic [N-1:0]   req_sh;
  logic [N-1:0]   wr_sh;
  logic [8*N-1:0] addr_sh;
  logic [8*N-1:0] wdata_sh;

  always_comb begin
    win_d  = last_q;
    any_d  = 1'b0;
    req_sh = '0;
    for (int unsigned off = N; off >= 1; off--) begin
      req_sh = req >> ((32'(last_q) + off) % N);
      if (req_sh[0]) begin
        win_d = 3'((32'(last_q) + off) % N);
        any_d = 1'b1;
      end
    end
  end

  always_comb begin
    wr_sh    = req_wr >> win_d;
    addr_sh  = req_addr >> {win_d, 3'b000};
    wdata_sh = req_wdata >> {win_d, 3'b000};
  end

  logic tmo;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);
  logic [15:0] cnt_q;

  // Held at zero while idle, so it enters ISSUE cleared and counts through
  // ISSUE and RELEASE.
  always_ff @(posedge clk) begin
    if (reset || state_q == S_IDLE || state_q == S_ACK) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign tmo = (state_q == S_ISSUE || state_q == S_RELEASE) && (cnt_q == TO_LIMIT);

  logic unused_ok;
  assign unused_ok = spi_busy;
`else
  assign tmo = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{spi_busy, 32'(TIMEOUT_CYCLES)};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      last_q  <= 3'(N - 1);
      ack_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_d) begin
            grant_q <= win_d;
            last_q  <= win_d;
            wr_q    <= wr_sh[0];
            addr_q  <= addr_sh[7:0];
            wdata_q <= wdata_sh[7:0];
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (tmo) begin
            start_q <= 1'b0;
            err_q   <= 1'b1;
            ack_q   <= ONE_HOT0 << grant_q;
            state_q <= S_ACK;
          end else if (spi_done) begin
            if (!wr_q) begin
              rdata_q <= spi_rdata;
            end
            start_q <= 1'b0;
            state_q <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (tmo) begin
            err_q   <= 1'b1;
            ack_q   <= ONE_HOT0 << grant_q;
            state_q <= S_ACK;
          end else if (!spi_done) begin
            ack_q   <= ONE_HOT0 << grant_q;
            state_q <= S_ACK;
          end
        end
        S_ACK: begin
          ack_q   <= '0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ack       = ack_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign grant_id  = grant_q;
  assign arb_busy  = busy_q;
  assign spi_start = start_q;
  assign spi_wr    = wr_q;
  assign spi_addr  = addr_q;
  assign spi_wdata = wdata_q;

endmodule

// File: tb/tb_spi_arbiter.sv
module tb_spi_arbiter;

  localparam int N = 4;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 4096;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   req_wr = '0;
  logic [8*N-1:0] req_addr = '0;
  logic [8*N-1:0] req_wdata = '0;
  logic [N-1:0]   ack;
  logic           err;
  logic [7:0]     rdata;
  logic [2:0]     grant_id;
  logic           arb_busy;
  logic           spi_start;
  logic           spi_wr;
  logic [7:0]     spi_addr;
  logic [7:0]     spi_wdata;
  logic [7:0]     spi_rdata = '0;
  logic           spi_done = 1'b0;
  logic           spi_busy;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  // SPI master model
  bit        model_en = 1'b1;
  int        done_dly = 0;
  logic [7:0] mem_rdata = 8'h00;
  int        dcnt = 0;

  spi_arbiter #(.N(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .ack(ack), .err(err), .rdata(rdata), .grant_id(grant_id),
    .arb_busy(arb_busy), .spi_start(spi_start), .spi_wr(spi_wr), .spi_addr(spi_addr),
    .spi_wdata(spi_wdata), .spi_rdata(spi_rdata), .spi_done(spi_done), .spi_busy(spi_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign spi_busy = spi_start | spi_done;

  always @(posedge clk) begin
    if (reset) begin
      spi_done <= 1'b0;
      dcnt     <= 0;
    end else if (model_en && spi_start && !spi_done) begin
      if (dcnt >= done_dly) begin
        spi_done  <= 1'b1;
        spi_rdata <= mem_rdata;
        dcnt      <= 0;
      end else begin
        dcnt <= dcnt + 1;
      end
    end else if (spi_done && !spi_start) begin
      spi_done <= 1'b0;
    end
  end

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (spi_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ack !== '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (ack !== 4'b0000) $display("FAIL rst_ack got=%b exp=0000", ack); else passed++;
    checks++; if (err !== 1'b0) $display("FAIL rst_err got=%b exp=0", err); else passed++;
    checks++; if (rdata !== 8'h00) $display("FAIL rst_rdata got=%h exp=00", rdata); else passed++;
    checks++; if (grant_id !== 3'd0) $display("FAIL rst_grant got=%0d exp=0", grant_id); else passed++;
    checks++; if (arb_busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", arb_busy); else passed++;
    checks++; if (spi_start !== 1'b0) $display("FAIL rst_start got=%b exp=0", spi_start); else passed++;
    checks++; if (spi_wr !== 1'b0) $display("FAIL rst_wr got=%b exp=0", spi_wr); else passed++;
    checks++; if (spi_addr !== 8'h00) $display("FAIL rst_addr got=%h exp=00", spi_addr); else passed++;
    checks++; if (spi_wdata !== 8'h00) $display("FAIL rst_wdata got=%h exp=00", spi_wdata); else passed++;
    reset = 1'b0;
  endtask

  task automatic test_single_write();
    bit   ok;
    int   fell;
    int   ack_cyc;
    logic pd;
    done_dly = 0;
    mem_rdata = 8'hEE;
    @(negedge clk);
    req_wr[0] = 1'b1;
    req_addr[7:0] = 8'h12;
    req_wdata[7:0] = 8'hA5;
    req = 4'b0001;
    @(negedge clk);
    checks++; if (spi_start !== 1'b1) $display("FAIL wr_start got=%b exp=1", spi_start); else passed++;
    checks++; if (spi_addr !== 8'h12) $display("FAIL wr_addr got=%h exp=12", spi_addr); else passed++;
    checks++; if (spi_wdata !== 8'hA5) $display("FAIL wr_wdata got=%h exp=a5", spi_wdata); else passed++;
    checks++; if (spi_wr !== 1'b1) $display("FAIL wr_wr got=%b exp=1", spi_wr); else passed++;
    checks++; if (arb_busy !== 1'b1) $display("FAIL wr_busy got=%b exp=1", arb_busy); else passed++;
    fell = -100;
    ack_cyc = 0;
    ok = 1'b0;
    pd = spi_done;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pd && !spi_done) fell = cyc;
      pd = spi_done;
      if (ack !== '0) begin
        ok = 1'b1;
        ack_cyc = cyc;
        break;
      end
    end
    req = '0;
    checks++; if (!ok) $display("FAIL wr_ack_wait no ack within 100 cycles"); else passed++;
    checks++; if (ack !== 4'b0001) $display("FAIL wr_ack got=%b exp=0001", ack); else passed++;
    checks++; if (err !== 1'b0) $display("FAIL wr_err got=%b exp=0", err); else passed++;
    checks++; if (ack_cyc - fell !== 1) $display("FAIL wr_ack_delay got=%0d exp=1", ack_cyc - fell); else passed++;
    checks++; if (rdata !== 8'h00) $display("FAIL wr_rdata_kept got=%h exp=00", rdata); else passed++;
    @(negedge clk);
    checks++; if (ack !== 4'b0000) $display("FAIL wr_ack_pulse got=%b exp=0000", ack); else passed++;
  endtask

  task automatic test_single_read();
    bit ok;
    mem_rdata = 8'h3C;
    req_wr[2] = 1'b0;
    req_addr[23:16] = 8'h40;
    req = 4'b0100;
    @(negedge clk);
    checks++; if (grant_id !== 3'd2) $display("FAIL rd_grant got=%0d exp=2", grant_id); else passed++;
    checks++; if (spi_wr !== 1'b0) $display("FAIL rd_wr got=%b exp=0", spi_wr); else passed++;
    checks++; if (spi_addr !== 8'h40) $display("FAIL rd_addr got=%h exp=40", spi_addr); else passed++;
    wait_ack(ok);
    req = '0;
    checks++; if (!ok) $display("FAIL rd_ack_wait no ack within 100 cycles"); else passed++;
    checks++; if (ack !== 4'b0100) $display("FAIL rd_ack got=%b exp=0100", ack); else passed++;
    checks++; if (rdata !== 8'h3C) $display("FAIL rd_rdata got=%h exp=3c", rdata); else passed++;
    @(negedge clk);
    checks++; if (rdata !== 8'h3C) $display("FAIL rd_rdata_hold got=%h exp=3c", rdata); else passed++;
  endtask

  task automatic test_early_drop();
    bit         ok;
    int         acks;
    logic [3:0] ack_val;
    done_dly = 3;
    mem_rdata = 8'h99;
    req_wr[1] = 1'b1;
    req_addr[15:8] = 8'h5A;
    req_wdata[15:8] = 8'h33;
    req = 4'b0010;
    wait_start(ok);
    checks++; if (!ok) $display("FAIL drop_start_wait no start within 100 cycles"); else passed++;
    checks++; if (grant_id !== 3'd1) $display("FAIL drop_grant got=%0d exp=1", grant_id); else passed++;
    req = '0;
    req_addr[15:8] = 8'hFF;
    @(negedge clk);
    checks++; if (spi_addr !== 8'h5A) $display("FAIL drop_addr_stable got=%h exp=5a", spi_addr); else passed++;
    acks = 0;
    ack_val = '0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (ack !== '0) begin
        acks++;
        ack_val = ack;
      end
    end
    checks++; if (acks !== 1) $display("FAIL drop_ack_count got=%0d exp=1", acks); else passed++;
    checks++; if (ack_val !== 4'b0010) $display("FAIL drop_ack got=%b exp=0010", ack_val); else passed++;
    checks++; if (rdata !== 8'h3C) $display("FAIL drop_rdata got=%h exp=3c", rdata); else passed++;
    checks++; if (arb_busy !== 1'b0) $display("FAIL drop_idle got=%b exp=0", arb_busy); else passed++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    done_dly = 10;
    req = 4'b1000;
    wait_start(ok);
    checks++; if (!ok) $display("FAIL rmid_start_wait no start within 100 cycles"); else passed++;
    checks++; if (grant_id !== 3'd3) $display("FAIL rmid_grant got=%0d exp=3", grant_id); else passed++;
    @(negedge clk);
    reset = 1'b1;
    req = '0;
    @(negedge clk);
    checks++; if (spi_start !== 1'b0) $display("FAIL rmid_start got=%b exp=0", spi_start); else passed++;
    checks++; if (arb_busy !== 1'b0) $display("FAIL rmid_busy got=%b exp=0", arb_busy); else passed++;
    checks++; if (ack !== 4'b0000) $display("FAIL rmid_ack got=%b exp=0000", ack); else passed++;
    reset = 1'b0;
    done_dly = 0;
    req = 4'b1111;
    wait_start(ok);
    checks++; if (!ok) $display("FAIL rmid_regrant_wait no start within 100 cycles"); else passed++;
    checks++; if (grant_id !== 3'd0) $display("FAIL rmid_regrant got=%0d exp=0", grant_id); else passed++;
    wait_ack(ok);
    req = '0;
    checks++; if (!ok) $display("FAIL rmid_ack_wait no ack within 100 cycles"); else passed++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_fairness();
    bit         ok;
    int         prev_start;
    logic [3:0] exp_ack;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    done_dly = 0;
    mem_rdata = 8'hC3;
    req = 4'b1111;
    prev_start = 0;
    for (int k = 0; k < 8; k++) begin
      wait_start(ok);
      checks++; if (!ok) $display("FAIL fair_start_wait k=%0d no start within 100 cycles", k); else passed++;
      checks++; if (grant_id !== 3'(k % 4)) $display("FAIL fair_grant k=%0d got=%0d exp=%0d", k, grant_id, k % 4); else passed++;
      if (k > 0) begin
        checks++; if (cyc - prev_start !== 6) $display("FAIL fair_gap k=%0d got=%0d exp=6", k, cyc - prev_start); else passed++;
      end
      prev_start = cyc;
      wait_ack(ok);
      if (k == 7) req = '0;
      exp_ack = 4'b0001 << (k % 4);
      checks++; if (ack !== exp_ack) $display("FAIL fair_ack k=%0d got=%b exp=%b", k, ack, exp_ack); else passed++;
      if (k % 4 == 2) begin
        checks++; if (rdata !== 8'hC3) $display("FAIL fair_rdata k=%0d got=%h exp=c3", k, rdata); else passed++;
      end
    end
    repeat (2) @(negedge clk);
  endtask

`ifdef SPI_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int s;
    model_en = 1'b0;
    req_wr[0] = 1'b0;
    req_addr[7:0] = 8'h77;
    req = 4'b0001;
    wait_start(ok);
    s = cyc;
    checks++; if (!ok) $display("FAIL to_start_wait no start within 100 cycles"); else passed++;
    wait_ack(ok);
    req = '0;
    checks++; if (!ok) $display("FAIL to_ack_wait no ack within 100 cycles"); else passed++;
    checks++; if (cyc - s !== 17) $display("FAIL to_delay got=%0d exp=17", cyc - s); else passed++;
    checks++; if (ack !== 4'b0001) $display("FAIL to_ack got=%b exp=0001", ack); else passed++;
    checks++; if (err !== 1'b1) $display("FAIL to_err got=%b exp=1", err); else passed++;
    checks++; if (spi_start !== 1'b0) $display("FAIL to_start got=%b exp=0", spi_start); else passed++;
    checks++; if (rdata !== 8'hC3) $display("FAIL to_rdata got=%h exp=c3", rdata); else passed++;
    @(negedge clk);
    checks++; if (err !== 1'b0) $display("FAIL to_err_pulse got=%b exp=0", err); else passed++;
    model_en = 1'b1;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_early_drop();
    test_reset_mid();
    test_fairness();
`ifdef SPI_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/spi_arbiter.md
# spi_arbiter

Round-robin arbiter that shares one SPI master among N requesters on the system clock domain. Each requester presents a register write or read (command select, 8-bit address, 8-bit write data). The arbiter grants one requester at a time and drives the master's level-held `start`/`done` handshake. It returns read data plus a one-cycle acknowledge to the granted requester. It sits between the register-access clients (init sequencer, host bridge, monitor) and the SPI master.

## Interface
Parameters:
- `N`, 4: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, 4096: watchdog limit in `clk` cycles. Used only with `SPI_ARB_TIMEOUT_EN`.

Ports:
- `clk` in 1: system clock, the same `clk` that runs the SPI master control FSM.
- `reset` in 1: synchronous, active-high.
- `req` in N: request per requester. Held high until `ack`.
- `req_wr` in N: 1 = write, 0 = read, per requester.
- `req_addr` in 8*N: register address, requester i at bits [8i+7:8i].
- `req_wdata` in 8*N: write data, same packing as `req_addr`.
- `ack` out N: one-cycle completion pulse to the granted requester.
- `err` out 1: pulses with `ack` when the transaction was aborted by timeout.
- `rdata` out 8: last read data. Valid while `ack` is high and held afterwards.
- `grant_id` out 3: index of the current or last granted requester.
- `arb_busy` out 1: high in any state other than IDLE.
- `spi_start` out 1: to master `start`.
- `spi_wr` out 1: to master `wr`.
- `spi_addr` out 8: to master `address`.
- `spi_wdata` out 8: to master `data_in`.
- `spi_rdata` in 8: from master `data_out`.
- `spi_done` in 1: from master `done`.
- `spi_busy` in 1: from master `busy`. Informational only, not used for sequencing.

## Operation
- FSM states: IDLE, ISSUE, RELEASE, ACK. All outputs are registered.
- **IDLE**
  - If any `req` bit is high, select the winner by round robin. Search starts at `(last_grant+1) mod N` and takes the first high bit.
  - Latch the winner's `req_wr`, `req_addr` and `req_wdata` into `spi_wr`, `spi_addr` and `spi_wdata`.
  - Set `grant_id` to the winner; update `last_grant`; go to ISSUE.
  - With no request, stay in IDLE.
- **ISSUE**
  - `spi_start`=1.
  - Stay until `spi_done`=1, then capture `spi_rdata` into `rdata` (reads only; `rdata` is unchanged on writes) and go to RELEASE.
- **RELEASE**
  - `spi_start`=0.
  - Stay until `spi_done`=0, then go to ACK. This satisfies the master's rule that `done` persists until `start` drops.
- **ACK**
  - `ack[grant_id]`=1 for exactly one cycle, then go to IDLE.
- Latched `spi_wr`, `spi_addr` and `spi_wdata` stay stable from entry to ISSUE until leaving RELEASE. Changes on `req_*` during a transaction are ignored.
- Requester rules:
  - Deasserting `req` before `ack` does not cancel the transaction; it completes and `ack` still pulses.
  - A requester that keeps `req` high after `ack` is treated as a new request in IDLE.
- Reset mid-operation:
  - The state goes to IDLE; `spi_start`, `ack` and `err` go to 0.
  - `last_grant` is set to N-1, so requester 0 has first priority.
  - The SPI master shares `reset` and returns to Idle in the same cycle.

## Timing
- Reset values: `ack`=0, `err`=0, `rdata`=0, `grant_id`=0, `arb_busy`=0, `spi_start`=0, `spi_wr`=0, `spi_addr`=0, `spi_wdata`=0.
- `req` is sampled in IDLE; `spi_start` rises 1 cycle later.
- Total transaction time is 3 + (cycles until `spi_done`=1) + (cycles until `spi_done`=0) clock cycles, from the IDLE decision cycle to the cycle after `ack`.
- Minimum gap between consecutive `spi_start` rising edges is 4 cycles. This happens when the master responds instantly.
- `arb_busy`=1 from the cycle after the grant through the ACK cycle.
- Fairness: with all N requesters held high, grants rotate 0,1,...,N-1,0 with no requester granted twice before every other active requester is granted once.

## Configuration
- `SPI_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to ISSUE and counts in ISSUE and RELEASE.
  - On reaching `TIMEOUT_CYCLES` the FSM forces `spi_start`=0 and goes directly to ACK with `err`=1. `rdata` is unchanged.
  - This covers a stopped `SPI_clk` or a missing `done`.
- Undefined: no counter is built; `err` is tied to 0; ISSUE and RELEASE wait indefinitely.

## Test plan
- Single write: `req`=4'b0001, `req_wr[0]`=1, addr 0x12, data 0xA5.
  - Required: `spi_start` rises 1 cycle later with `spi_addr`=0x12 and `spi_wdata`=0xA5.
  - Required: `ack`=4'b0001 one cycle after `spi_done` falls; `err`=0.
- Single read: requester 2, addr 0x40, master model returns 0x3C.
  - Required: `rdata`=0x3C and `ack`=4'b0100.
- Fairness: all four `req` held high for 8 transactions.
  - Required: `grant_id` sequence 0,1,2,3,0,1,2,3.
- Early drop: requester 1 drops `req` while `spi_start`=1.
  - Required: transaction completes and `ack[1]` pulses once.
- Reset during ISSUE.
  - Required: next cycle `spi_start`=0 and `arb_busy`=0.
  - Required: next grant with all `req` high goes to requester 0.
- Timeout (`SPI_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16): `spi_done` held 0.
  - Required: `ack` and `err` pulse together 17 cycles after `spi_start` rises.
  - Required: `spi_start`=0 and `rdata` unchanged.
